// File: rtl/fetch_entry_queue.sv
// Fetch-entry queue: realigns 32-bit fetch words into 16/32-bit instructions
// (including ones that straddle two words) and buffers them for decode.
module fetch_entry_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned VLEN  = 64
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            flush_i,
   input  logic            fetch_valid_i,
   output logic            fetch_ready_o,
   input  logic [VLEN-1:0] fetch_addr_i,
   input  logic [31:0]     fetch_data_i,
   input  logic            fetch_ex_valid_i,
   output logic            fetch_entry_valid_o,
   input  logic            fetch_entry_ready_i,
   output logic [VLEN-1:0] fetch_entry_addr_o,
   output logic [31:0]     fetch_entry_instr_o,
   output logic            fetch_entry_ex_valid_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   typedef enum logic [0:0] {StAligned, StHeld} state_e;

   state_e            state_q, state_d;
   logic [15:0]       held_q, held_d;
   logic [VLEN-1:0]   held_addr_q, held_addr_d;

   logic [VLEN-1:0]   mem_addr  [DEPTH];
   logic [31:0]       mem_instr [DEPTH];
   logic              mem_ex    [DEPTH];
   logic [PtrW-1:0]   wptr_q, rptr_q, idx_b;
   logic [CntW-1:0]   count_q, free;

   logic              accept, pop, do_hi;
   logic              push_a, push_b, ex_a;
   logic [1:0]        n_push;
   logic [VLEN-1:0]   addr_a, addr_b, addr_hi;
   logic [31:0]       instr_a, instr_b;
   logic [15:0]       lo, hi;

   function automatic logic is_comp(input logic [1:0] b);
      return b != 2'b11;
   endfunction

   // Handshake is driven purely from the registered count, never from decode ready.
   assign free                = CntW'(DEPTH) - count_q;
   assign fetch_ready_o       = (free >= CntW'(2)) && !flush_i;
   assign fetch_entry_valid_o = (count_q != '0) && !flush_i;
   assign pop                 = fetch_entry_valid_o && fetch_entry_ready_i;
   assign accept              = fetch_valid_i && fetch_ready_o;

   assign lo      = fetch_data_i[15:0];
   assign hi      = fetch_data_i[31:16];
   assign addr_hi = {fetch_addr_i[VLEN-1:2], 2'b10};

   // Entry a is the older instruction (held straddle or low halfword), b the upper halfword.
   assign n_push = {1'b0, push_a} + {1'b0, push_b};
   assign idx_b  = push_a ? wptr_q + PtrW'(1) : wptr_q;

   assign fetch_entry_addr_o     = mem_addr[rptr_q];
   assign fetch_entry_instr_o    = mem_instr[rptr_q];
   assign fetch_entry_ex_valid_o = mem_ex[rptr_q];

   // Realigner next state and the entries produced by an accepted word.
   always_comb begin
      state_d     = state_q;
      held_d      = held_q;
      held_addr_d = held_addr_q;
      push_a      = 1'b0;
      push_b      = 1'b0;
      ex_a        = 1'b0;
      do_hi       = 1'b0;
      addr_a      = fetch_addr_i;
      instr_a     = fetch_data_i;
      addr_b      = addr_hi;
      instr_b     = {16'b0, hi};
      if (accept) begin
         if (fetch_ex_valid_i) begin
            // A fault yields one entry; in HELD it is charged to the straddling instruction.
            push_a  = 1'b1;
            ex_a    = 1'b1;
            addr_a  = (state_q == StHeld) ? held_addr_q : fetch_addr_i;
            state_d = StAligned;
         end else begin
            unique case (state_q)
               StHeld: begin
                  push_a  = 1'b1;
                  addr_a  = held_addr_q;
                  instr_a = {lo, held_q};
                  do_hi   = 1'b1;
               end
               StAligned: begin
                  if (!fetch_addr_i[1]) begin
                     push_a = 1'b1;
                     if (is_comp(lo[1:0])) begin
                        instr_a = {16'b0, lo};
                        do_hi   = 1'b1;
                     end
                  end else begin
                     do_hi = 1'b1;
                  end
               end
            endcase
            if (do_hi) begin
               if (is_comp(hi[1:0])) begin
                  push_b  = 1'b1;
                  state_d = StAligned;
               end else begin
                  held_d      = hi;
                  held_addr_d = addr_hi;
                  state_d     = StHeld;
               end
            end
         end
      end
   end

   // Control state: reset and flush both empty the queue and realign.
   always_ff @(posedge clk_i) begin
      if (!rst_ni || flush_i) begin
         state_q     <= StAligned;
         held_q      <= '0;
         held_addr_q <= '0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         held_q      <= held_d;
         held_addr_q <= held_addr_d;
         wptr_q      <= wptr_q + PtrW'(n_push);
         rptr_q      <= rptr_q + PtrW'(pop);
         count_q     <= count_q + CntW'(n_push) - CntW'(pop);
      end
   end

   // Entry storage, written in program order; contents need no reset.
   always_ff @(posedge clk_i) begin
      if (push_a) begin
         mem_addr[wptr_q]  <= addr_a;
         mem_instr[wptr_q] <= instr_a;
         mem_ex[wptr_q]    <= ex_a;
      end
      if (push_b) begin
         mem_addr[idx_b]  <= addr_b;
         mem_instr[idx_b] <= instr_b;
         mem_ex[idx_b]    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fetch_entry_queue.sv
// Directed bench for fetch_entry_queue with hand-computed expectations.
module tb_fetch_entry_queue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        f_valid;
   logic        f_ready;
   logic [63:0] f_addr;
   logic [31:0] f_data;
   logic        f_ex;
   logic        e_valid;
   logic        e_ready;
   logic [63:0] e_addr;
   logic [31:0] e_instr;
   logic        e_ex;

   int checks = 0;
   int errors = 0;

   fetch_entry_queue #(.DEPTH(4), .VLEN(64)) dut (
      .clk_i                  (clk),
      .rst_ni                 (rst_n),
      .flush_i                (flush),
      .fetch_valid_i          (f_valid),
      .fetch_ready_o          (f_ready),
      .fetch_addr_i           (f_addr),
      .fetch_data_i           (f_data),
      .fetch_ex_valid_i       (f_ex),
      .fetch_entry_valid_o    (e_valid),
      .fetch_entry_ready_i    (e_ready),
      .fetch_entry_addr_o     (e_addr),
      .fetch_entry_instr_o    (e_instr),
      .fetch_entry_ex_valid_o (e_ex)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one fetch word and hold it until accepted (bounded wait).
   task automatic push(input logic [63:0] a, input logic [31:0] d, input logic ex);
      int n = 0;
      f_valid = 1'b1;
      f_addr  = a;
      f_data  = d;
      f_ex    = ex;
      while (!f_ready && n < 20) begin
         step();
         n++;
      end
      if (!f_ready) chk("push_timeout", 64'(f_ready), 64'd1);
      step();
      f_valid = 1'b0;
      f_ex    = 1'b0;
   endtask

   // Check the head entry, then pop it.
   task automatic expect_pop(input string tag, input logic [63:0] a, input logic [31:0] ins,
                             input logic ex);
      chk({tag, "_valid"}, 64'(e_valid), 64'd1);
      chk({tag, "_addr"}, e_addr, a);
      chk({tag, "_instr"}, 64'(e_instr), 64'(ins));
      chk({tag, "_ex"}, 64'(e_ex), 64'(ex));
      e_ready = 1'b1;
      step();
      e_ready = 1'b0;
   endtask

   initial begin
      rst_n   = 1'b0;
      flush   = 1'b0;
      f_valid = 1'b0;
      f_addr  = '0;
      f_data  = '0;
      f_ex    = 1'b0;
      e_ready = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      chk("rst_valid", 64'(e_valid), 64'd0);
      chk("rst_ready", 64'(f_ready), 64'd1);

      // Single 32-bit instruction
      push(64'h8000_0000, 32'h0000_0013, 1'b0);
      expect_pop("single", 64'h8000_0000, 32'h0000_0013, 1'b0);
      chk("single_empty", 64'(e_valid), 64'd0);

      // Two compressed instructions in one word
      push(64'h1000, 32'h4501_4505, 1'b0);
      expect_pop("c0", 64'h1000, 32'h0000_4505, 1'b0);
      expect_pop("c1", 64'h1002, 32'h0000_4501, 1'b0);
      chk("c_empty", 64'(e_valid), 64'd0);

      // Straddling 32-bit instruction
      push(64'h1000, 32'h0013_4505, 1'b0);
      push(64'h1004, 32'h0001_0000, 1'b0);
      expect_pop("s0", 64'h1000, 32'h0000_4505, 1'b0);
      expect_pop("s1", 64'h1002, 32'h0000_0013, 1'b0);
      expect_pop("s2", 64'h1006, 32'h0000_0001, 1'b0);
      chk("s_empty", 64'(e_valid), 64'd0);

      // Backpressure: count 3 leaves one free slot, so fetch stalls
      push(64'h3000, 32'h0010_0013, 1'b0);
      chk("bp_ready1", 64'(f_ready), 64'd1);
      push(64'h3004, 32'h0020_0013, 1'b0);
      chk("bp_ready2", 64'(f_ready), 64'd1);
      push(64'h3008, 32'h0030_0013, 1'b0);
      chk("bp_ready3", 64'(f_ready), 64'd0);
      chk("bp_head_a", e_addr, 64'h3000);
      step();
      step();
      step();
      chk("bp_stable_a", e_addr, 64'h3000);
      chk("bp_stable_i", 64'(e_instr), 64'h0010_0013);
      expect_pop("bp0", 64'h3000, 32'h0010_0013, 1'b0);
      chk("bp_ready_rel", 64'(f_ready), 64'd1);
      expect_pop("bp1", 64'h3004, 32'h0020_0013, 1'b0);
      expect_pop("bp2", 64'h3008, 32'h0030_0013, 1'b0);
      chk("bp_empty", 64'(e_valid), 64'd0);

      // Flush while a halfword is held
      push(64'h1000, 32'h0013_4505, 1'b0);
      chk("fl_pre_valid", 64'(e_valid), 64'd1);
      flush = 1'b1;
      #1;
      chk("fl_cyc_valid", 64'(e_valid), 64'd0);
      chk("fl_cyc_ready", 64'(f_ready), 64'd0);
      step();
      flush = 1'b0;
      #1;
      chk("fl_post_valid", 64'(e_valid), 64'd0);
      chk("fl_post_ready", 64'(f_ready), 64'd1);
      push(64'h2002, 32'h4505_0000, 1'b0);
      expect_pop("fl_e", 64'h2002, 32'h0000_4505, 1'b0);
      chk("fl_empty", 64'(e_valid), 64'd0);

      // Fault on the second half of a straddle, then reset with the queue non-empty
      push(64'h1000, 32'h0013_4505, 1'b0);
      push(64'h1004, 32'hdead_beef, 1'b1);
      expect_pop("fx0", 64'h1000, 32'h0000_4505, 1'b0);
      chk("fx_valid", 64'(e_valid), 64'd1);
      chk("fx_addr", e_addr, 64'h1002);
      chk("fx_instr", 64'(e_instr), 64'hdead_beef);
      chk("fx_ex", 64'(e_ex), 64'd1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      #1;
      chk("rst2_valid", 64'(e_valid), 64'd0);
      chk("rst2_ready", 64'(f_ready), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
